// File: rtl/uart2wifi_core_pkg.sv
// -----------------------------------------------------------------------------
// uart2wifi_core_pkg
// Shared types and defaults for the uart2wifi core transmit path.
//   tx_state_e  : transmit sequencer states
//   par_mode_e  : parity sense selected by cfg_parity_odd
//   DATA_W_DEF  : default data bits per frame
//   CNT_W_DEF   : default width of the transmitted-frame counter
// -----------------------------------------------------------------------------
package uart2wifi_core_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic {
        PAR_EVEN = 1'b0,
        PAR_ODD  = 1'b1
    } par_mode_e;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_POP    = 3'd1,
        TX_LOAD   = 3'd2,
        TX_START  = 3'd3,
        TX_DATA   = 3'd4,
        TX_PARITY = 3'd5,
        TX_STOP   = 3'd6
    } tx_state_e;

endpackage

// File: rtl/uart2wifi_core_tx_shift.sv
// -----------------------------------------------------------------------------
// uart2wifi_core_tx_shift
// Data path of the UART transmitter: LSB-first shift register, bit index and
// even-parity accumulator of the loaded byte.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   i_load       : load i_data, clear bit index, latch parity of i_data
//   i_data       : byte to serialise
//   i_shift      : shift right one place, advance bit index
//   o_bit0       : current LSB (first data bit after load)
//   o_bit1       : bit that becomes the LSB after the next shift
//   o_last       : bit index points at the final data bit
//   o_par_even   : XOR of all loaded data bits
// -----------------------------------------------------------------------------
module uart2wifi_core_tx_shift #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_shift,
    output logic              o_bit0,
    output logic              o_bit1,
    output logic              o_last,
    output logic              o_par_even
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    logic [DATA_W-1:0] r_shift;
    logic [IDX_W-1:0]  r_bit_idx;
    logic              r_par_even;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift    <= '0;
            r_bit_idx  <= '0;
            r_par_even <= 1'b0;
        end else if (i_load) begin
            r_shift    <= i_data;
            r_bit_idx  <= '0;
            r_par_even <= ^i_data;
        end else if (i_shift) begin
            r_shift    <= {1'b0, r_shift[DATA_W-1:1]};
            r_bit_idx  <= r_bit_idx + IDX_W'(1);
        end
    end

    assign o_bit0     = r_shift[0];
    assign o_bit1     = r_shift[1];
    assign o_last     = (r_bit_idx == IDX_W'(DATA_W - 1));
    assign o_par_even = r_par_even;

endmodule

// File: rtl/uart2wifi_core_tx_ctrl.sv
// -----------------------------------------------------------------------------
// uart2wifi_core_tx_ctrl
// UART transmit sequencer. Pops one byte from the TX FIFO when enabled and
// idle, then frames it on tx: start bit, LSB-first data, optional parity,
// one or two stop bits. Every bit boundary falls on a baud_tick.
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   cfg_en          : transmitter enable
//   cfg_parity_en   : append parity bit
//   cfg_parity_odd  : 1 = odd parity, 0 = even
//   cfg_two_stop    : 1 = two stop bits, 0 = one
//   baud_tick       : one-clock pulse per bit period
//   fifo_empty      : TX FIFO empty
//   fifo_rd         : one-clock pop strobe to the FIFO
//   fifo_rdata      : FIFO data, valid the cycle after fifo_rd
//   tx              : serial line, idle high
//   busy            : frame in progress (pop through last stop bit)
//   frame_done      : one-clock pulse at the end of the last stop bit
//   byte_cnt        : frames completed since reset (wraps)
//   dbg_state       : current sequencer state
//
// FIFO handshake: fifo_rd is a registered strobe raised only from IDLE when
// cfg_en && !fifo_empty, for exactly one cycle (the POP cycle). The FIFO
// presents the popped word on fifo_rdata during the following cycle, so the
// shift register loads on the first LOAD cycle. One pop per frame.
// -----------------------------------------------------------------------------
module uart2wifi_core_tx_ctrl
    import uart2wifi_core_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_en,
    input  logic              cfg_parity_en,
    input  logic              cfg_parity_odd,
    input  logic              cfg_two_stop,
    input  logic              baud_tick,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    input  logic [DATA_W-1:0] fifo_rdata,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  byte_cnt,
    output tx_state_e         dbg_state
);

    tx_state_e        r_state;
    logic             r_tx;
    logic             r_fifo_rd;
    logic             r_busy;
    logic             r_frame_done;
    logic [CNT_W-1:0] r_byte_cnt;
    logic             r_snap_par_en;
    logic             r_snap_odd;
    logic             r_snap_two;
    logic             r_stop_second;
    logic             r_cap;

    tx_state_e        w_state_nx;
    logic             w_tx_nx;
    logic             w_fifo_rd_nx;
    logic             w_frame_done_nx;
    logic [CNT_W-1:0] w_cnt_nx;
    logic             w_stop_second_nx;
    logic             w_shift;
    logic             w_snap;
    logic             w_bit0;
    logic             w_bit1;
    logic             w_last;
    logic             w_par_even;
    logic             w_par;

    uart2wifi_core_tx_shift #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk        (clk),
        .rst        (rst),
        .i_load     (r_cap),
        .i_data     (fifo_rdata),
        .i_shift    (w_shift),
        .o_bit0     (w_bit0),
        .o_bit1     (w_bit1),
        .o_last     (w_last),
        .o_par_even (w_par_even)
    );

    // Parity sense comes from the snapshot, so a mid-frame cfg change is ignored.
    assign w_par = (par_mode_e'(r_snap_odd) == PAR_ODD) ? ~w_par_even : w_par_even;

    always_comb begin
        w_state_nx       = r_state;
        w_tx_nx          = r_tx;
        w_fifo_rd_nx     = 1'b0;
        w_frame_done_nx  = 1'b0;
        w_cnt_nx         = r_byte_cnt;
        w_stop_second_nx = r_stop_second;
        w_shift          = 1'b0;
        w_snap           = 1'b0;
        case (r_state)
            TX_IDLE: begin
                w_tx_nx = 1'b1;
                if (cfg_en && !fifo_empty) begin
                    w_fifo_rd_nx = 1'b1;
                    w_state_nx   = TX_POP;
                end
            end
            TX_POP: begin
                w_snap     = 1'b1;
                w_state_nx = TX_LOAD;
            end
            TX_LOAD: begin
                // Wait for a tick so the start bit is a full bit period.
                w_tx_nx = 1'b1;
                if (baud_tick) begin
                    w_tx_nx    = 1'b0;
                    w_state_nx = TX_START;
                end
            end
            TX_START: begin
                if (baud_tick) begin
                    w_tx_nx    = w_bit0;
                    w_state_nx = TX_DATA;
                end
            end
            TX_DATA: begin
                if (baud_tick) begin
                    if (!w_last) begin
                        w_shift = 1'b1;
                        w_tx_nx = w_bit1;
                    end else if (r_snap_par_en) begin
                        w_tx_nx    = w_par;
                        w_state_nx = TX_PARITY;
                    end else begin
                        w_tx_nx          = 1'b1;
                        w_stop_second_nx = 1'b0;
                        w_state_nx       = TX_STOP;
                    end
                end
            end
            TX_PARITY: begin
                if (baud_tick) begin
                    w_tx_nx          = 1'b1;
                    w_stop_second_nx = 1'b0;
                    w_state_nx       = TX_STOP;
                end
            end
            TX_STOP: begin
                if (baud_tick) begin
                    if (r_snap_two && !r_stop_second) begin
                        w_stop_second_nx = 1'b1;
                    end else begin
                        w_frame_done_nx = 1'b1;
                        w_cnt_nx        = r_byte_cnt + CNT_W'(1);
                        w_state_nx      = TX_IDLE;
                    end
                end
            end
            default: begin
                w_tx_nx    = 1'b1;
                w_state_nx = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= TX_IDLE;
            r_tx          <= 1'b1;
            r_fifo_rd     <= 1'b0;
            r_busy        <= 1'b0;
            r_frame_done  <= 1'b0;
            r_byte_cnt    <= '0;
            r_snap_par_en <= 1'b0;
            r_snap_odd    <= 1'b0;
            r_snap_two    <= 1'b0;
            r_stop_second <= 1'b0;
            r_cap         <= 1'b0;
        end else begin
            r_state       <= w_state_nx;
            r_tx          <= w_tx_nx;
            r_fifo_rd     <= w_fifo_rd_nx;
            r_busy        <= (w_state_nx != TX_IDLE);
            r_frame_done  <= w_frame_done_nx;
            r_byte_cnt    <= w_cnt_nx;
            r_stop_second <= w_stop_second_nx;
            // High exactly on the first LOAD cycle, when fifo_rdata is valid.
            r_cap         <= (r_state == TX_POP);
            if (w_snap) begin
                r_snap_par_en <= cfg_parity_en;
                r_snap_odd    <= cfg_parity_odd;
                r_snap_two    <= cfg_two_stop;
            end
        end
    end

    assign fifo_rd    = r_fifo_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;
    assign byte_cnt   = r_byte_cnt;
    assign dbg_state  = r_state;

endmodule

// File: tb/tb_uart2wifi_core_tx_ctrl.sv
module tb_uart2wifi_core_tx_ctrl;
    import uart2wifi_core_pkg::*;

    localparam int CLK_PER_TICK = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        cfg_en = 1'b0;
    logic        cfg_parity_en = 1'b0;
    logic        cfg_parity_odd = 1'b0;
    logic        cfg_two_stop = 1'b0;
    logic        baud_tick = 1'b0;
    logic        fifo_empty = 1'b1;
    logic [7:0]  fifo_rdata = 8'h00;
    logic        fifo_rd;
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [15:0] byte_cnt;
    tx_state_e   dbg_state;

    uart2wifi_core_tx_ctrl #(.DATA_W(8), .CNT_W(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_en         (cfg_en),
        .cfg_parity_en  (cfg_parity_en),
        .cfg_parity_odd (cfg_parity_odd),
        .cfg_two_stop   (cfg_two_stop),
        .baud_tick      (baud_tick),
        .fifo_empty     (fifo_empty),
        .fifo_rd        (fifo_rd),
        .fifo_rdata     (fifo_rdata),
        .tx             (tx),
        .busy           (busy),
        .frame_done     (frame_done),
        .byte_cnt       (byte_cnt),
        .dbg_state      (dbg_state)
    );

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    // ---------------- baud tick: one pulse every CLK_PER_TICK clocks ----------------
    int tick_c = 0;
    initial begin
        forever begin
            @(negedge clk);
            tick_c++;
            baud_tick = ((tick_c % CLK_PER_TICK) == 0);
        end
    end

    // ---------------- FIFO model: data valid the cycle after the pop ----------------
    logic [7:0] fifo_q[$];
    logic       rd_pend = 1'b0;
    logic [7:0] rd_byte = 8'h00;
    int         pop_cnt = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (rd_pend) begin
                fifo_rdata = rd_byte;
                rd_pend = 1'b0;
            end
            if (fifo_rd === 1'b1) begin
                check("pop_nonempty", 32'(fifo_q.size() > 0), 32'd1);
                if (fifo_q.size() > 0) begin
                    rd_byte = fifo_q.pop_front();
                    rd_pend = 1'b1;
                    pop_cnt++;
                end
                fifo_rdata = 8'($urandom);
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       two_stop;
    } frame_t;

    frame_t exp_frames[$];

    // Serial bit list of one frame from the framing rules.
    function automatic void build_bits(input frame_t f, output logic [15:0] b, output int n);
        b = '0;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = f.data[i];
        n = 9;
        if (f.par_en) begin
            b[n] = f.par_odd ? ~(^f.data) : (^f.data);
            n++;
        end
        b[n] = 1'b1;
        n++;
        if (f.two_stop) begin
            b[n] = 1'b1;
            n++;
        end
    endfunction

    logic        rx_on = 1'b0;
    int          rx_t = 0;
    int          rx_n = 0;
    logic [15:0] rx_bits = '0;
    int          model_cnt = 0;
    int          done_cnt = 0;

    initial begin
        frame_t f;
        forever begin
            @(negedge clk);
            if (!rst) begin
                rx_on = 1'b0;
                model_cnt = 0;
            end else if (!rx_on) begin
                if (tx === 1'b0) begin
                    if (exp_frames.size() == 0) begin
                        check("rx_unexpected_start", 32'(exp_frames.size()), 32'd1);
                        repeat (150) @(negedge clk);
                    end else begin
                        f = exp_frames.pop_front();
                        build_bits(f, rx_bits, rx_n);
                        rx_on = 1'b1;
                        rx_t = 0;
                    end
                end
            end else begin
                rx_t++;
                if ((rx_t % 10) == 5 && (rx_t / 10) < rx_n)
                    check("rx_bit", 32'(tx), 32'(rx_bits[rx_t/10]));
                if (rx_t == 10 * rx_n - 1) begin
                    check("rx_busy_last", 32'(busy), 32'd1);
                    check("rx_done_early", 32'(frame_done), 32'd0);
                end
                if (rx_t == 10 * rx_n) begin
                    model_cnt++;
                    check("rx_frame_done", 32'(frame_done), 32'd1);
                    check("rx_busy_drop", 32'(busy), 32'd0);
                    check("rx_byte_cnt", 32'(byte_cnt), 32'(16'(model_cnt)));
                    done_cnt++;
                    rx_on = 1'b0;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [7:0] d);
        frame_t f;
        f.data = d;
        f.par_en = cfg_parity_en;
        f.par_odd = cfg_parity_odd;
        f.two_stop = cfg_two_stop;
        exp_frames.push_back(f);
        fifo_q.push_back(d);
        fifo_empty = 1'b0;
    endtask

    task automatic wait_done(input int target, input string name);
        int t;
        t = 0;
        while (done_cnt < target && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check(name, 32'(done_cnt >= target), 32'd1);
    endtask

    // Measures one frame from start-bit detection to frame_done, sampling mid-bit.
    task automatic measure(output int len, output logic [15:0] bits, output logic ok);
        int t;
        ok = 1'b0;
        bits = '0;
        len = 0;
        t = 0;
        while (tx !== 1'b0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (tx === 1'b0) begin
            t = 0;
            while (frame_done !== 1'b1 && t < 300) begin
                @(negedge clk);
                t++;
                if ((t % 10) == 5 && (t / 10) < 16) bits[t/10] = tx;
            end
            len = t;
            ok = (frame_done === 1'b1);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       par_en;
        logic       par_odd;
        logic       two_stop;
        int         nbits;
        logic       par_bit;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int          len;
        logic [15:0] bits;
        logic        ok;
        int          d0;
        int          p0;
        int          g;
        int          viol;
        int          t;
        int          n;
        logic [9:0]  a5_pat;

        vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 10, 1'b0};
        vecs[1] = '{8'h03, 1'b1, 1'b0, 1'b0, 11, 1'b0};
        vecs[2] = '{8'h03, 1'b1, 1'b1, 1'b0, 11, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b1, 11, 1'b0};
        vecs[4] = '{8'hFF, 1'b1, 1'b0, 1'b1, 12, 1'b0};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 1'b0, 11, 1'b0};
        vecs[6] = '{8'h00, 1'b1, 1'b1, 1'b1, 12, 1'b1};
        a5_pat = 10'b1101001010;

        // ---- reset state ----
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_fifo_rd", 32'(fifo_rd), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(TX_IDLE));
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // ---- table-driven single frames ----
        cfg_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            cfg_parity_en = vecs[i].par_en;
            cfg_parity_odd = vecs[i].par_odd;
            cfg_two_stop = vecs[i].two_stop;
            d0 = done_cnt;
            push(vecs[i].data);
            measure(len, bits, ok);
            check("vec_frame_seen", 32'(ok), 32'd1);
            check("vec_frame_len", 32'(len), 32'(10 * vecs[i].nbits));
            if (vecs[i].par_en) check("vec_parity_bit", 32'(bits[9]), 32'(vecs[i].par_bit));
            if (i == 0) check("a5_pattern", 32'(bits[9:0]), 32'(a5_pat));
            wait_done(d0 + 1, "vec_wait_done");
            repeat (30) @(negedge clk);
            check("vec_done_once", 32'(done_cnt - d0), 32'd1);
        end

        // ---- back-to-back 0x55, 0xAA ----
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop = 1'b0;
        d0 = done_cnt;
        p0 = pop_cnt;
        n = int'(byte_cnt);
        push(8'h55);
        push(8'hAA);
        t = 0;
        while (frame_done !== 1'b1 && t < 400) begin
            @(negedge clk);
            t++;
        end
        check("b2b_first_done", 32'(frame_done), 32'd1);
        g = 0;
        while (tx !== 1'b0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("b2b_gap_le_bit", 32'(g <= CLK_PER_TICK), 32'd1);
        wait_done(d0 + 2, "b2b_wait_done");
        repeat (30) @(negedge clk);
        check("b2b_pops", 32'(pop_cnt - p0), 32'd2);
        check("b2b_byte_cnt", 32'(byte_cnt), 32'(16'(n + 2)));
        check("b2b_fifo_empty", 32'(fifo_empty), 32'd1);

        // ---- idle: FIFO empty, then disabled with data waiting ----
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("idle_empty_quiet", 32'(viol), 32'd0);
        cfg_en = 1'b0;
        p0 = pop_cnt;
        d0 = done_cnt;
        push(8'h5A);
        viol = 0;
        repeat (200) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        check("idle_disabled_quiet", 32'(viol), 32'd0);
        check("idle_disabled_no_pop", 32'(pop_cnt - p0), 32'd0);
        cfg_en = 1'b1;
        wait_done(d0 + 1, "enable_wait_done");

        // ---- mid-frame cfg change and disable ----
        d0 = done_cnt;
        p0 = pop_cnt;
        push(8'h3C);
        t = 0;
        while (busy !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("mid_busy_seen", 32'(busy), 32'd1);
        repeat (3) @(negedge clk);
        cfg_parity_en = 1'b1;
        cfg_two_stop = 1'b1;
        cfg_parity_odd = 1'b1;
        cfg_en = 1'b0;
        wait_done(d0 + 1, "mid_cfg_wait_done");
        push(8'hC3);
        repeat (60) @(negedge clk);
        check("mid_disabled_pops", 32'(pop_cnt - p0), 32'd1);
        cfg_en = 1'b1;
        wait_done(d0 + 2, "mid_reenable_done");
        repeat (20) @(negedge clk);

        // ---- asynchronous reset during data bit 3 ----
        cfg_parity_en = 1'b0;
        cfg_parity_odd = 1'b0;
        cfg_two_stop = 1'b0;
        push(8'h3C);
        t = 0;
        while (tx !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("rstmid_start_seen", 32'(tx), 32'd0);
        repeat (45) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("rstmid_tx", 32'(tx), 32'd1);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_byte_cnt", 32'(byte_cnt), 32'd0);
        check("rstmid_state", 32'(dbg_state), 32'(TX_IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        d0 = done_cnt;
        push(8'h96);
        wait_done(d0 + 1, "rstmid_after_done");
        repeat (5) @(negedge clk);
        check("rstmid_after_cnt", 32'(byte_cnt), 32'd1);

        // ---- randomized bursts against the reference model ----
        for (int r = 0; r < 12; r++) begin
            cfg_parity_en = 1'($urandom_range(0, 1));
            cfg_parity_odd = 1'($urandom_range(0, 1));
            cfg_two_stop = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 3));
            d0 = done_cnt;
            p0 = pop_cnt;
            for (int k = 0; k < n; k++) push(8'($urandom));
            wait_done(d0 + n, "rand_wait_done");
            repeat (15) @(negedge clk);
            check("rand_pops", 32'(pop_cnt - p0), 32'(n));
        end

        check("final_scoreboard_empty", 32'(exp_frames.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
